// File: rtl/arb_req_client_pkg.sv
// -----------------------------------------------------------------------------
// arb_pkg
// Shared constants, types and helpers for the requester-side arbiter client.
//   N          : number of requesters (width of req/gnt vectors)
//   CNT_W      : width of each per-requester pending counter
//   STARVE_MAX : cycles a request may wait without a grant before it is flagged
// -----------------------------------------------------------------------------
package arb_pkg;

  localparam int N          = 16;
  localparam int CNT_W      = 4;
  localparam int STARVE_MAX = 32;
  localparam int IDX_W      = $clog2(N);

  typedef logic [N-1:0]     req_vec_t;
  typedef logic [IDX_W-1:0] idx_t;

  // Encode a one-hot vector. OR-ing the indices of all set bits gives the
  // exact index for one-hot input and needs no priority chain.
  function automatic idx_t onehot_to_idx(input req_vec_t v);
    idx_t idx;
    idx = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) idx = idx | idx_t'(i);
    end
    return idx;
  endfunction

  // True when exactly one bit is set.
  function automatic logic is_onehot(input req_vec_t v);
    return (v != '0) && ((v & (v - req_vec_t'(1))) == '0);
  endfunction

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic idx_t lowest_idx(input req_vec_t v);
    idx_t idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = idx_t'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_req_client_if.sv
// -----------------------------------------------------------------------------
// arb_req_client_if
// Bundle of the client's request/grant and status signals.
//   push, gnt, err_clr          : driven by the environment (master)
//   full, req, gnt_vld, gnt_idx,
//   ovf, gnt_err, starve,
//   starve_idx                  : driven by the client (slave)
// -----------------------------------------------------------------------------
interface arb_req_client_if;
  import arb_pkg::*;

  req_vec_t push;
  req_vec_t full;
  req_vec_t req;
  req_vec_t gnt;
  logic     gnt_vld;
  idx_t     gnt_idx;
  logic     ovf;
  logic     gnt_err;
  logic     starve;
  idx_t     starve_idx;
  logic     err_clr;

  modport slave (
    input  push, gnt, err_clr,
    output full, req, gnt_vld, gnt_idx, ovf, gnt_err, starve, starve_idx
  );

  modport master (
    output push, gnt, err_clr,
    input  full, req, gnt_vld, gnt_idx, ovf, gnt_err, starve, starve_idx
  );

endinterface

// File: rtl/arb_req_client_slot.sv
// -----------------------------------------------------------------------------
// arb_client_slot
// One requester's pending-transaction counter and starvation timer.
//   clk, rst   : clock and asynchronous active-low reset
//   push       : add one pending transaction (dropped when full, no dec)
//   dec        : a validated grant consumed one transaction this cycle
//   req_bit    : registered, count != 0
//   full_bit   : registered, count == maximum
//   starve_hit : timer has reached STARVE_MAX
// -----------------------------------------------------------------------------
module arb_client_slot #(
  parameter int CNT_W      = 4,
  parameter int STARVE_MAX = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic dec,
  output logic req_bit,
  output logic full_bit,
  output logic starve_hit
);

  localparam int                 TMR_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]   CNT_MAX = '1;
  localparam logic [TMR_W-1:0]   TMR_MAX = TMR_W'(STARVE_MAX);

  logic [CNT_W-1:0] count_reg, count_next;
  logic [TMR_W-1:0] tmr_reg, tmr_next;
  logic             req_reg, full_reg;

  always_comb begin
    count_next = count_reg;
    // push together with dec cancels out; a push into a full slot is dropped.
    if (push && !dec) begin
      if (count_reg != CNT_MAX) count_next = count_reg + CNT_W'(1);
    end else if (dec && !push) begin
      // dec is only ever raised while req_reg is high, so no underflow.
      count_next = count_reg - CNT_W'(1);
    end
  end

  always_comb begin
    tmr_next = tmr_reg;
    if (!req_reg || dec) begin
      tmr_next = '0;
    end else if (tmr_reg != TMR_MAX) begin
      tmr_next = tmr_reg + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_reg <= '0;
      tmr_reg   <= '0;
      req_reg   <= 1'b0;
      full_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      tmr_reg   <= tmr_next;
      // Registered from the next count so req/full track the count exactly.
      req_reg   <= (count_next != '0);
      full_reg  <= (count_next == CNT_MAX);
    end
  end

  assign req_bit    = req_reg;
  assign full_bit   = full_reg;
  assign starve_hit = (tmr_reg == TMR_MAX);

endmodule

// File: rtl/arb_req_client.sv
// -----------------------------------------------------------------------------
// arb_req_client
// Requester-side companion to a round-robin arbiter. Queues per-requester
// transaction counts, drives req, validates and encodes the arbiter's gnt,
// and raises sticky flags on overflow, malformed grants and starvation.
//   clk : clock, rising edge
//   rst : asynchronous reset, active-low
//   bus : arb_req_client_if.slave
//         push/gnt/err_clr in; full/req/gnt_vld/gnt_idx/ovf/gnt_err/
//         starve/starve_idx out
// -----------------------------------------------------------------------------
module arb_req_client
  import arb_pkg::*;
#(
  parameter int CNT_W_P      = arb_pkg::CNT_W,
  parameter int STARVE_MAX_P = arb_pkg::STARVE_MAX
) (
  input  logic             clk,
  input  logic             rst,
  arb_req_client_if.slave  bus
);

  req_vec_t req_vec, full_vec, starve_vec;
  req_vec_t dec_vec, ovf_vec;
  logic     gnt_valid, gnt_bad;

  logic     gnt_vld_reg, gnt_vld_next;
  idx_t     gnt_idx_reg, gnt_idx_next;
  logic     ovf_reg, ovf_next;
  logic     gnt_err_reg, gnt_err_next;
  logic     starve_reg, starve_next;
  idx_t     starve_idx_reg, starve_idx_next;

  // A grant is only honoured when it is one-hot and lands on a requester
  // that is actually asking; anything else non-zero is malformed.
  always_comb begin
    gnt_valid = is_onehot(bus.gnt) && ((bus.gnt & req_vec) != '0);
    gnt_bad   = (bus.gnt != '0) && !gnt_valid;
    dec_vec   = gnt_valid ? bus.gnt : '0;
    ovf_vec   = bus.push & full_vec & ~dec_vec;
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slot
      arb_client_slot #(
        .CNT_W      (CNT_W_P),
        .STARVE_MAX (STARVE_MAX_P)
      ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .push       (bus.push[gi]),
        .dec        (dec_vec[gi]),
        .req_bit    (req_vec[gi]),
        .full_bit   (full_vec[gi]),
        .starve_hit (starve_vec[gi])
      );
    end
  endgenerate

  always_comb begin
    gnt_vld_next    = gnt_valid;
    // Index holds its last value between pulses; it is only meaningful
    // while gnt_vld is high.
    gnt_idx_next    = gnt_valid ? onehot_to_idx(bus.gnt) : gnt_idx_reg;
    ovf_next        = ovf_reg;
    gnt_err_next    = gnt_err_reg;
    starve_next     = starve_reg;
    starve_idx_next = starve_idx_reg;
    if (bus.err_clr) begin
      // Clear wins; a persisting condition re-sets the flag a cycle later.
      ovf_next        = 1'b0;
      gnt_err_next    = 1'b0;
      starve_next     = 1'b0;
      starve_idx_next = '0;
    end else begin
      ovf_next     = ovf_reg | (|ovf_vec);
      gnt_err_next = gnt_err_reg | gnt_bad;
      // Capture only the first starvation event; the index is frozen after.
      if (!starve_reg && (|starve_vec)) begin
        starve_next     = 1'b1;
        starve_idx_next = lowest_idx(starve_vec);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_vld_reg    <= 1'b0;
      gnt_idx_reg    <= '0;
      ovf_reg        <= 1'b0;
      gnt_err_reg    <= 1'b0;
      starve_reg     <= 1'b0;
      starve_idx_reg <= '0;
    end else begin
      gnt_vld_reg    <= gnt_vld_next;
      gnt_idx_reg    <= gnt_idx_next;
      ovf_reg        <= ovf_next;
      gnt_err_reg    <= gnt_err_next;
      starve_reg     <= starve_next;
      starve_idx_reg <= starve_idx_next;
    end
  end

  assign bus.req        = req_vec;
  assign bus.full       = full_vec;
  assign bus.gnt_vld    = gnt_vld_reg;
  assign bus.gnt_idx    = gnt_idx_reg;
  assign bus.ovf        = ovf_reg;
  assign bus.gnt_err    = gnt_err_reg;
  assign bus.starve     = starve_reg;
  assign bus.starve_idx = starve_idx_reg;

endmodule

// File: tb/tb_arb_req_client.sv
// -----------------------------------------------------------------------------
// tb_arb_req_client
// Self-checking bench for arb_req_client: a table of directed single-cycle
// vectors, then hand-written sequences for fill/overflow, starvation,
// a rotating-push run against a round-robin arbiter model, and mid-run reset.
// -----------------------------------------------------------------------------
module tb_arb_req_client;
  import arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_req_client_if bus();

  arb_req_client dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    req_vec_t push;
    req_vec_t gnt;
    logic     clr;
    req_vec_t exp_req;
    req_vec_t exp_full;
    logic     exp_vld;
    idx_t     exp_idx;
    logic     exp_ovf;
    logic     exp_err;
    logic     exp_starve;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input req_vec_t p, input req_vec_t g, input logic c);
    bus.push    = p;
    bus.gnt     = g;
    bus.err_clr = c;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_req"},     32'(bus.req),        32'h0);
    chk({tag, "_full"},    32'(bus.full),       32'h0);
    chk({tag, "_vld"},     32'(bus.gnt_vld),    32'h0);
    chk({tag, "_idx"},     32'(bus.gnt_idx),    32'h0);
    chk({tag, "_ovf"},     32'(bus.ovf),        32'h0);
    chk({tag, "_gnterr"},  32'(bus.gnt_err),    32'h0);
    chk({tag, "_starve"},  32'(bus.starve),     32'h0);
    chk({tag, "_sidx"},    32'(bus.starve_idx), 32'h0);
  endtask

  // Round-robin model arbiter state for the rotating run.
  int       mcnt [N];
  int       rr_ptr;

  initial begin
    req_vec_t m, g, p, mreq;
    int       pick, consumed;

    // push, gnt, clr | req, full, vld, idx, ovf, err, starve
    tbl[0]  = '{16'h0005, 16'h0000, 1'b0, 16'h0005, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{16'h0000, 16'h0001, 1'b0, 16'h0004, 16'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{16'h0000, 16'h0004, 1'b0, 16'h0000, 16'h0, 1'b1, 4'd2, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{16'h0003, 16'h0000, 1'b0, 16'h0003, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{16'h0000, 16'h0003, 1'b0, 16'h0003, 16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{16'h0000, 16'h0000, 1'b1, 16'h0003, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{16'h0000, 16'h0100, 1'b0, 16'h0003, 16'h0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{16'h0000, 16'h0000, 1'b1, 16'h0003, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{16'h0000, 16'h0001, 1'b0, 16'h0002, 16'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{16'h0000, 16'h0002, 1'b0, 16'h0000, 16'h0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{16'h0010, 16'h0000, 1'b0, 16'h0010, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{16'h0001, 16'h0010, 1'b0, 16'h0001, 16'h0, 1'b1, 4'd4, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{16'h0000, 16'h0001, 1'b0, 16'h0000, 16'h0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0};

    // ---- reset and idle ----
    rst = 1'b0;
    drive('0, '0, 1'b0);
    repeat (3) step();
    chk_all_zero("in_reset");
    rst = 1'b1;
    step();
    chk_all_zero("post_reset");
    repeat (20) step();
    chk("idle_gnt_err", 32'(bus.gnt_err), 32'h0);
    chk("idle_vld",     32'(bus.gnt_vld), 32'h0);

    // ---- directed vector table ----
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].push, tbl[i].gnt, tbl[i].clr);
      step();
      chk($sformatf("v%0d_req", i),    32'(bus.req),     32'(tbl[i].exp_req));
      chk($sformatf("v%0d_full", i),   32'(bus.full),    32'(tbl[i].exp_full));
      chk($sformatf("v%0d_vld", i),    32'(bus.gnt_vld), 32'(tbl[i].exp_vld));
      if (tbl[i].exp_vld)
        chk($sformatf("v%0d_idx", i),  32'(bus.gnt_idx), 32'(tbl[i].exp_idx));
      chk($sformatf("v%0d_ovf", i),    32'(bus.ovf),     32'(tbl[i].exp_ovf));
      chk($sformatf("v%0d_err", i),    32'(bus.gnt_err), 32'(tbl[i].exp_err));
      chk($sformatf("v%0d_starve", i), 32'(bus.starve),  32'(tbl[i].exp_starve));
      $display("vec %0d push=%h gnt=%h clr=%b -> req=%h vld=%b idx=%0d err=%b",
               i, tbl[i].push, tbl[i].gnt, tbl[i].clr, bus.req, bus.gnt_vld, bus.gnt_idx, bus.gnt_err);
    end

    // ---- all requesters pushed at once, then drained one per cycle ----
    drive(16'hFFFF, '0, 1'b0);
    step();
    chk("allpush_req", 32'(bus.req), 32'hFFFF);
    for (int i = 0; i < N; i++) begin
      g = req_vec_t'(1) << i;
      m = req_vec_t'(16'hFFFF) << (i + 1);
      drive('0, g, 1'b0);
      step();
      chk($sformatf("drain%0d_vld", i), 32'(bus.gnt_vld), 32'h1);
      chk($sformatf("drain%0d_idx", i), 32'(bus.gnt_idx), 32'(i));
      chk($sformatf("drain%0d_req", i), 32'(bus.req),     32'(m));
      $display("drain %0d gnt=%h -> vld=%b idx=%0d req=%h", i, g, bus.gnt_vld, bus.gnt_idx, bus.req);
    end
    drive('0, '0, 1'b0);
    step();
    chk("drain_done_vld", 32'(bus.gnt_vld), 32'h0);

    // ---- fill bit 3 to full, overflow, push+grant ----
    for (int k = 0; k < 15; k++) begin
      drive(16'h0008, '0, 1'b0);
      step();
      if (k == 13) chk("fill14_full", 32'(bus.full), 32'h0);
    end
    chk("fill15_full", 32'(bus.full), 32'h0008);
    chk("fill15_ovf",  32'(bus.ovf),  32'h0);
    step();  // 16th push, dropped
    chk("ovf_set",     32'(bus.ovf),  32'h1);
    chk("ovf_full",    32'(bus.full), 32'h0008);
    drive(16'h0008, 16'h0008, 1'b0);
    step();
    chk("pg_vld",  32'(bus.gnt_vld), 32'h1);
    chk("pg_idx",  32'(bus.gnt_idx), 32'h3);
    chk("pg_full", 32'(bus.full),    32'h0008);
    $display("push+grant bit3 -> vld=%b idx=%0d full=%h", bus.gnt_vld, bus.gnt_idx, bus.full);
    // 15 transactions must still be pending
    for (int k = 0; k < 15; k++) begin
      drive('0, 16'h0008, 1'b0);
      step();
      chk($sformatf("f_drain%0d_vld", k), 32'(bus.gnt_vld), 32'h1);
      chk($sformatf("f_drain%0d_req3", k), 32'(bus.req[3]), 32'((k < 14) ? 1 : 0));
    end
    drive('0, '0, 1'b1);
    step();
    chk("ovf_clr", 32'(bus.ovf), 32'h0);
    drive('0, '0, 1'b0);
    step();

    // ---- starvation on bits 5 and 9 ----
    drive(16'h0220, '0, 1'b0);
    step();
    drive('0, '0, 1'b0);
    repeat (32) step();
    chk("starve_early", 32'(bus.starve), 32'h0);
    step();
    chk("starve_set", 32'(bus.starve),     32'h1);
    chk("starve_idx", 32'(bus.starve_idx), 32'h5);
    drive('0, '0, 1'b1);
    step();
    chk("starve_clr",     32'(bus.starve),     32'h0);
    chk("starve_idx_clr", 32'(bus.starve_idx), 32'h0);
    drive('0, '0, 1'b0);
    step();
    chk("starve_reset",     32'(bus.starve),     32'h1);
    chk("starve_idx_reset", 32'(bus.starve_idx), 32'h5);
    drive('0, 16'h0020, 1'b0);
    step();
    chk("sv_g5_idx", 32'(bus.gnt_idx), 32'h5);
    drive('0, 16'h0200, 1'b0);
    step();
    chk("sv_g9_idx", 32'(bus.gnt_idx), 32'h9);
    drive('0, '0, 1'b1);
    step();
    drive('0, '0, 1'b0);
    step();
    chk("starve_gone", 32'(bus.starve), 32'h0);
    chk("req_empty",   32'(bus.req),    32'h0);

    // ---- rotating pushes against a round-robin model arbiter ----
    for (int i = 0; i < N; i++) mcnt[i] = 0;
    rr_ptr   = 0;
    consumed = 0;
    for (int cyc = 0; cyc < 140; cyc++) begin
      p = (cyc < 100) ? (req_vec_t'(1) << (cyc % 16)) : '0;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        if (pick < 0 && mcnt[(rr_ptr + k) % N] != 0) pick = (rr_ptr + k) % N;
      end
      g = (pick >= 0) ? (req_vec_t'(1) << pick) : '0;
      drive(p, g, 1'b0);
      step();
      for (int i = 0; i < N; i++) if (p[i]) mcnt[i]++;
      if (pick >= 0) begin
        mcnt[pick]--;
        rr_ptr = (pick + 1) % N;
      end
      mreq = '0;
      for (int i = 0; i < N; i++) mreq[i] = (mcnt[i] != 0);
      chk($sformatf("rot%0d_vld", cyc), 32'(bus.gnt_vld), 32'((pick >= 0) ? 1 : 0));
      if (pick >= 0) begin
        chk($sformatf("rot%0d_idx", cyc), 32'(bus.gnt_idx), 32'(pick));
        if (bus.gnt_vld && (32'(bus.gnt_idx) == 32'(pick))) consumed++;
      end
      chk($sformatf("rot%0d_req", cyc), 32'(bus.req), 32'(mreq));
      $display("rot %0d push=%h gnt=%h -> vld=%b idx=%0d req=%h",
               cyc, p, g, bus.gnt_vld, bus.gnt_idx, bus.req);
      if (cyc >= 100 && mreq == '0 && pick < 0) break;
    end
    chk("rot_consumed", 32'(consumed),     32'd100);
    chk("rot_ovf",      32'(bus.ovf),      32'h0);
    chk("rot_gnt_err",  32'(bus.gnt_err),  32'h0);
    chk("rot_starve",   32'(bus.starve),   32'h0);

    // ---- reset mid-operation discards pending counts immediately ----
    drive(16'hFFFF, '0, 1'b0);
    step();
    chk("mid_req_before", 32'(bus.req), 32'hFFFF);
    drive('0, '0, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("mid_req_async", 32'(bus.req), 32'h0);
    step();
    rst = 1'b1;
    step();
    chk_all_zero("mid_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arb_req_client.md
# arb_req_client

Requester-side companion to the 16-way round-robin arbiter. It queues per-requester transaction counts and drives the arbiter's `req` vector. It consumes the arbiter's one-hot `gnt`, returning one transaction per valid grant as an encoded index. It also polices the arbiter: malformed grants and starvation raise sticky flags. It sits between the client request sources and the arbiter, wired `req`→arbiter `req` and arbiter `gnt`→`gnt`.

## Interface
- `N`, 16: number of requesters; width of `req` and `gnt`.
- `CNT_W`, 4: pending-count width per requester; maximum pending is 2^CNT_W−1 (15).
- `STARVE_MAX`, 32: consecutive cycles a requester may hold `req` without a grant before starvation is flagged.

- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous reset, active-low.
- `push`  in  N: per-bit add one pending transaction for that requester.
- `full`  out  N: per-bit pending count equals maximum.
- `req`  out  N: to arbiter; bit i high iff count[i] ≠ 0.
- `gnt`  in  N: from arbiter; expected one-hot or zero.
- `gnt_vld`  out  1: one transaction consumed last cycle.
- `gnt_idx`  out  $clog2(N): index of the consumed transaction.
- `ovf`  out  1: sticky; a push was dropped because its requester was full.
- `gnt_err`  out  1: sticky; malformed grant seen.
- `starve`  out  1: sticky; a starvation threshold was hit.
- `starve_idx`  out  $clog2(N): lowest index that hit starvation first; frozen while `starve` is set.
- `err_clr`  in  1: synchronous clear of `ovf`, `gnt_err`, `starve` and `starve_idx`.

## Operation
- Each per-requester count[i] updates once per clock:
  - `push[i]` alone: +1.
  - valid grant to i alone: −1.
  - Both in the same cycle: unchanged.
  - `push[i]` while full with no grant: push dropped, count unchanged, `ovf` set.
- Valid grant: `gnt` is exactly one-hot, say bit i, and `req[i]`=1. It decrements count[i], and the next cycle shows `gnt_vld`=1, `gnt_idx`=i.
- Malformed grants set `gnt_err`, change no counts and give `gnt_vld`=0:
  - multi-hot `gnt`;
  - one-hot `gnt` to a bit whose `req` is 0.
- `gnt`=0 is idle. It is not an error.
- Starvation timer per requester:
  - increments while `req[i]`=1 and no valid grant to i;
  - clears on a valid grant to i or when `req[i]`=0;
  - saturates at STARVE_MAX.
  - Reaching STARVE_MAX sets `starve`. If `starve` was clear, `starve_idx` latches the lowest such i.
- `err_clr` has priority over setting a flag in the same cycle. The flag clears, and any condition that persists re-sets it on the next cycle.

## Timing
- Reset values: all counts 0, `req`=0, `full`=0, `gnt_vld`=0, `gnt_idx`=0, `ovf`=0, `gnt_err`=0, `starve`=0, `starve_idx`=0, timers 0.
- Reset asserted mid-operation discards all pending counts immediately; there is no drain.
- `req` and `full` are registered functions of the counts. `push` at edge t gives `req` high after edge t.
- Grant latency: `gnt` sampled at edge t gives `gnt_vld`/`gnt_idx` valid from edge t to t+1 for one cycle. The count decrement and `req` drop are visible after the same edge t.
- `gnt_vld` is a single-cycle pulse per consumed transaction. Back-to-back valid grants give consecutive pulses.
- Throughput: one grant consumed per cycle. A push for every requester in the same cycle is accepted in one cycle.

## Structure
- Package `arb_pkg` holds:
  - defaults for N, CNT_W and STARVE_MAX;
  - typedef `req_vec_t` (logic [N-1:0]);
  - function `onehot_to_idx`;
  - function `is_onehot`.
- Sub-module `arb_client_slot` is instantiated N times. Each instance holds one count and one starvation timer, with outputs `req_bit`, `full_bit`, `starve_hit`.
- The top level holds:
  - grant validation and encoding;
  - the `gnt_vld`/`gnt_idx` register;
  - the sticky flags and lowest-index capture.

## Test plan
- Reset then idle: after `rst` high, all outputs 0. `gnt`=0 for 20 cycles leaves `gnt_err`=0.
- Push and drain:
  - `push`=16'h0005 for one cycle → `req`=16'h0005.
  - `gnt`=16'h0001 → next cycle `gnt_vld`=1, `gnt_idx`=0, `req`=16'h0004.
  - `gnt`=16'h0004 → `gnt_idx`=2, `req`=0.
- Full and overflow:
  - 15 pushes on bit 3 → `full[3]`=1.
  - 16th push → `ovf`=1, count stays 15.
  - Simultaneous push and grant on bit 3 → count stays 15, `gnt_vld`=1.
- Bad grants: `gnt`=16'h0003 with `req`=16'h0003 → `gnt_err`=1, `gnt_vld`=0, counts unchanged. After `err_clr`, `gnt`=16'h0100 with `req[8]`=0 → `gnt_err`=1 again.
- Starvation: hold `req[5]` and `req[9]` for 32 cycles with `gnt`=0 → `starve`=1, `starve_idx`=5. `err_clr` clears both, and they re-set next cycle while the condition persists.
- Rotating single-bit pushes, 100 cycles (the arbiter bench pattern) with a model arbiter → every push returns exactly one `gnt_vld` with the matching `gnt_idx`, and no flags are set.
